sram_ctrl_seq: RTL and testbench
================================

SRAM_CTRL_SEQ -- requirements
Module: sram_ctrl_seq

Interface
REQ-001 Parameter DATA_W, default 16: data bus width in bits.
REQ-002 Parameter ADDR_W, default 18: address width in bits.
REQ-003 Parameter WAIT_CYC, default 2, legal range 1..15: cycles during which the strobe (ram_we or ram_oe) is held asserted per access.
REQ-004 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports, in order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  block enable; when 0, req_ready SHALL be 0.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- addr_in  in  ADDR_W  request address.
- data_in  in  DATA_W  write data.
- done  out  1  one-cycle pulse when an access completes.
- data_out  out  DATA_W  read data, valid when done=1 and the access was a read.
- err  out  1  verify-mismatch pulse (see REQ-020).
- ram_en  out  1  SRAM chip enable, active-low.
- ram_oe  out  1  SRAM output enable, active-low.
- ram_we  out  1  SRAM write enable, active-low.
- addr  out  ADDR_W  SRAM address.
- data  inout  DATA_W  SRAM data bus; high-Z unless the block is writing.

Function
REQ-006 States: IDLE, SETUP, WSTROBE, WHOLD, RSTROBE, DONE.
REQ-007 req_ready SHALL be 1 only when state=IDLE and en=1; acceptance occurs on the clk edge where req_valid and req_ready are both 1.
REQ-008 On acceptance, addr_in, data_in and req_we SHALL be registered; later changes to these inputs SHALL NOT affect the access in progress.
REQ-009 SETUP (1 cycle): ram_en=0; addr driven; ram_we=1; ram_oe=1. On a write, data is driven from the first SETUP cycle.
REQ-010 Write path:
- SETUP -> WSTROBE, which holds ram_we=0 for exactly WAIT_CYC cycles.
- WSTROBE -> WHOLD (1 cycle): ram_we=1, with data and addr still driven.
- WHOLD -> DONE.
REQ-011 Read path:
- SETUP -> RSTROBE, which holds ram_oe=0 for exactly WAIT_CYC cycles.
- The data bus SHALL be sampled into data_out on the last RSTROBE cycle.
- RSTROBE -> DONE.
REQ-012 DONE (1 cycle): done=1; ram_en=1, ram_oe=1, ram_we=1; data bus released; next state is IDLE.
REQ-013 Latency from the acceptance edge to done high: write = 3+WAIT_CYC cycles; read = 2+WAIT_CYC cycles.
REQ-014 data_out SHALL hold its value until the next read completes.
REQ-015 ram_we and ram_oe SHALL never be 0 in the same cycle; the data bus SHALL never be driven while ram_oe=0.
REQ-016 The wait counter SHALL be 4 bits and SHALL reload at every strobe entry; it SHALL NOT wrap within an access.
REQ-017 Deasserting en mid-access SHALL NOT abort the access; it only blocks new acceptance.

Reset
REQ-018 While rst=1 at a clk edge, the block SHALL:
- go to state=IDLE;
- set ram_en=1, ram_oe=1, ram_we=1;
- release the data bus to high-Z;
- set addr=0, data_out=0, done=0, err=0, req_ready=0.
REQ-019 Reset asserted mid-access SHALL abandon the access at that edge, with no done pulse.

Configuration
REQ-020 With macro SRAM_CTRL_WVERIFY_EN defined, every write SHALL be followed, after WHOLD, by a read of the same address:
- sequence: SETUP, RSTROBE, DONE;
- done pulses only at the end of the readback;
- err=1 for that DONE cycle if the readback differs from the written data;
- write latency becomes 5+2*WAIT_CYC.
Without the macro, err SHALL be tied to 0 and no readback occurs.

Verification
REQ-021 Reset, then write 0x000E to addr 0x00005 with WAIT_CYC=2 -> ram_we low for exactly 2 cycles, data=0x000E from SETUP through WHOLD, done high 5 cycles after acceptance.
REQ-022 Read addr 0x00005, SRAM model returning 0x000E -> ram_oe low for 2 cycles, done high 4 cycles after acceptance, data_out=0x000E, data bus never driven.
REQ-023 Hold req_valid high continuously with alternating we -> req_ready high only in IDLE, back-to-back accesses with one IDLE cycle between them, no strobe overlap.
REQ-024 Assert rst during WSTROBE -> next edge: ram_we=1, ram_en=1, bus high-Z, no done pulse.
REQ-025 With SRAM_CTRL_WVERIFY_EN, and an SRAM model corrupting bit 0, write 0x00FF -> done and err high together 9 cycles after acceptance; with a clean model, err stays 0.
REQ-026 Toggle en=0 during a read -> the read completes normally and the next request is not accepted until en=1.

Source files
------------

// File: rtl/sram_ctrl_seq.sv
// Sequencer for a single-port asynchronous SRAM: one read or write per request.
// Optional macro SRAM_CTRL_WVERIFY_EN reads back every write and pulses err on mismatch.
module sram_ctrl_seq #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              err,
  output logic              ram_en,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WSTROBE, S_WHOLD, S_RSTROBE, S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);

  state_t            r_state;
  logic [3:0]        r_wait;
  logic              r_we;
  logic              r_rb;
  logic              r_turn;
  logic              r_drive;
  logic              r_done;
  logic              r_err;
  logic              r_ram_en;
  logic              r_ram_oe;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_dout;
  logic              w_ready;

  assign w_ready   = (r_state == S_IDLE) && en && !rst;
  assign req_ready = w_ready;
  assign done      = r_done;
  assign err       = r_err;
  assign data_out  = r_dout;
  assign ram_en    = r_ram_en;
  assign ram_oe    = r_ram_oe;
  assign ram_we    = r_ram_we;
  assign addr      = r_addr;
  assign data      = r_drive ? r_wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_we     <= 1'b0;
      r_rb     <= 1'b0;
      r_turn   <= 1'b0;
      r_drive  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ram_en <= 1'b1;
      r_ram_oe <= 1'b1;
      r_ram_we <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_dout   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && w_ready) begin
            r_we     <= req_we;
            r_addr   <= addr_in;
            r_wdata  <= data_in;
            r_drive  <= req_we;
            r_rb     <= 1'b0;
            r_turn   <= 1'b0;
            r_ram_en <= 1'b0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          // r_turn stretches the readback setup by one cycle so the bus can turn around
          if (r_turn) begin
            r_turn <= 1'b0;
          end else begin
            r_wait <= WAIT_LD;
            if (r_we && !r_rb) begin
              r_ram_we <= 1'b0;
              r_state  <= S_WSTROBE;
            end else begin
              r_ram_oe <= 1'b0;
              r_state  <= S_RSTROBE;
            end
          end
        end
        S_WSTROBE: begin
          if (r_wait == 4'd0) begin
            r_ram_we <= 1'b1;
            r_state  <= S_WHOLD;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_WHOLD: begin
          r_drive <= 1'b0;
`ifdef SRAM_CTRL_WVERIFY_EN
          r_rb    <= 1'b1;
          r_turn  <= 1'b1;
          r_state <= S_SETUP;
`else
          r_ram_en <= 1'b1;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
`endif
        end
        S_RSTROBE: begin
          if (r_wait == 4'd0) begin
            r_ram_oe <= 1'b1;
            r_ram_en <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
`ifdef SRAM_CTRL_WVERIFY_EN
            if (r_rb) r_err <= (data != r_wdata);
            else      r_dout <= data;
`else
            r_dout <= data;
`endif
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_DONE: begin
          r_rb    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl_seq.sv
// Randomized bench for sram_ctrl_seq against a memory-map reference and latency formulas.
module tb_sram_ctrl_seq;
  localparam int DW = 16;
  localparam int AW = 18;
  localparam int WC = 2;
`ifdef SRAM_CTRL_WVERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int LAT_W = VERIFY ? 5 + 2*WC : 3 + WC;
  localparam int LAT_R = 2 + WC;

  logic          clk = 1'b0;
  logic          rst, en, req_valid, req_we;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          req_ready, done, err, ram_en, ram_oe, ram_we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  wire  [DW-1:0] data;

  logic [DW-1:0] sram    [0:63];
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] exp_dout;
  logic          corrupt;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  sram_ctrl_seq #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .addr_in(addr_in), .data_in(data_in), .done(done),
    .data_out(data_out), .err(err), .ram_en(ram_en), .ram_oe(ram_oe),
    .ram_we(ram_we), .addr(addr), .data(data)
  );

  // SRAM model; corrupt flips bit 0 of stored data
  assign data = (!ram_en && !ram_oe) ? sram[addr[5:0]] : {DW{1'bz}};
  always @(posedge clk) if (!ram_en && !ram_we) sram[addr[5:0]] <= data ^ DW'(corrupt);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst) chk("strobe_overlap", 32'(ram_we | ram_oe), 1);

  task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic drop_en);
    int n, tmo, we_lo, oe_lo, lat;
    logic bad_addr, bad_wdata, stray_err, got_done, exp_err;
    lat = we ? LAT_W : LAT_R;
    exp_err = we && VERIFY && corrupt;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; addr_in = a; data_in = d;
    tmo = 0;
    while (!req_ready && tmo < 20) begin @(negedge clk); tmo++; end
    chk("accept_timeout", 32'(tmo < 20), 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); addr_in = AW'($urandom); data_in = DW'($urandom);
    if (drop_en) en = 1'b0;
    n = 1; we_lo = 0; oe_lo = 0; got_done = 0;
    bad_addr = 0; bad_wdata = 0; stray_err = 0;
    while (n <= 40) begin
      if (!ram_we) we_lo++;
      if (!ram_oe) oe_lo++;
      if (we && n <= WC + 2 && data !== d) bad_wdata = 1;
      if (!ram_en && addr !== a) bad_addr = 1;
      if (done) begin got_done = 1; break; end
      if (err) stray_err = 1;
      @(posedge clk); #1; n++;
    end
    if (we) ref_mem[a[5:0]] = d ^ DW'(corrupt);
    else    exp_dout = ref_mem[a[5:0]];
    chk("done_seen", 32'(got_done), 1);
    chk("latency", n, lat);
    chk("we_low_cycles", we_lo, we ? WC : 0);
    chk("oe_low_cycles", oe_lo, (!we || VERIFY) ? WC : 0);
    chk("addr_hold", 32'(bad_addr), 0);
    chk("wdata_bus", 32'(bad_wdata), 0);
    chk("err_at_done", 32'(err), 32'(exp_err));
    chk("err_stray", 32'(stray_err), 0);
    chk("data_out", 32'(data_out), 32'(exp_dout));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 0);
    chk("ram_idle", 32'({ram_en, ram_oe, ram_we}), 3'b111);
    if (drop_en) begin
      req_valid = 1'b1; req_we = 1'b0; addr_in = '0;
      repeat (4) begin
        @(negedge clk);
        chk("en_blocks_ready", 32'(req_ready), 0);
        chk("en_blocks_access", 32'(ram_en), 1);
      end
      req_valid = 1'b0;
      en = 1'b1;
    end
  endtask

  initial begin
    logic prev_done, acc, pend_we, seen;
    logic [5:0] pend_a;
    int nd, tmo;
    rst = 1'b1; en = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    addr_in = '0; data_in = '0; corrupt = 1'b0; exp_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_ram", 32'({ram_en, ram_oe, ram_we}), 3'b111);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;

    do_access(1'b1, 18'h00005, 16'h000E, 1'b0);
    do_access(1'b0, 18'h00005, 16'h0000, 1'b0);
    chk("read_0x5", 32'(data_out), 32'h000E);

    for (int i = 0; i < 32; i++) do_access(1'b1, AW'(i), DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++)
      do_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom), 1'b0);

    // back-to-back: req_valid held high, direction alternating
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; addr_in = AW'($urandom_range(0, 31)); data_in = DW'($urandom);
    prev_done = 0; nd = 0; pend_we = 0; pend_a = '0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        chk("b2b_rdy_in_done", 32'(req_ready), 0);
        if (!pend_we) begin
          exp_dout = ref_mem[pend_a];
          chk("b2b_rdata", 32'(data_out), 32'(exp_dout));
        end
        nd++;
      end
      if (prev_done) chk("b2b_rdy_after_done", 32'(req_ready), 1);
      if (!ram_en) chk("b2b_rdy_busy", 32'(req_ready), 0);
      prev_done = done;
      acc = req_ready;
      @(posedge clk);
      if (acc) begin
        pend_we = req_we; pend_a = addr_in[5:0];
        if (req_we) ref_mem[pend_a] = data_in;
        #1;
        req_we = ~req_we; addr_in = AW'($urandom_range(0, 31)); data_in = DW'($urandom);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_dones", 32'(nd >= 2 * (60 / (LAT_W + LAT_R + 2))), 1);
    repeat (20) begin
      @(negedge clk);
      if (done && !pend_we) exp_dout = ref_mem[pend_a];
    end

    // reset during the write strobe abandons the access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; addr_in = 18'd40; data_in = DW'($urandom);
    tmo = 0;
    while (!req_ready && tmo < 20) begin @(negedge clk); tmo++; end
    chk("abort_accept_timeout", 32'(tmo < 20), 1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_wstrobe", 32'(ram_we), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ram", 32'({ram_en, ram_oe, ram_we}), 3'b111);
    chk("abort_done", 32'(done), 0);
    chk("abort_dout", 32'(data_out), 0);
    @(negedge clk); rst = 1'b0; exp_dout = '0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (done) seen = 1; end
    chk("abort_no_done", 32'(seen), 0);

    do_access(1'b0, AW'($urandom_range(0, 31)), '0, 1'b1);
    do_access(1'b1, AW'($urandom_range(0, 31)), DW'($urandom), 1'b0);

    corrupt = 1'b1;
    do_access(1'b1, 18'd7, 16'h00FF, 1'b0);
    corrupt = 1'b0;
    do_access(1'b0, 18'd7, '0, 1'b0);
    chk("corrupt_readback", 32'(data_out), 32'h00FE);
    do_access(1'b1, 18'd7, 16'h00FF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
